// File: rtl/std_fifo_sync_vr.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module std_fifo_sync_vr #(
    parameter int FIFO_WIDTH       = 8,
    parameter int FIFO_DEPTH_LOG2  = 2,
    parameter int FIFO_AFULL_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FIFO_WIDTH-1:0]      s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_WIDTH-1:0]      m_data,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       almost_full
);

    localparam int                   D     = 1 << FIFO_DEPTH_LOG2;
    localparam int                   PW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]        ONE   = PW'(1);
    localparam logic [PW-1:0]        AFULL = PW'(FIFO_AFULL_LEVEL);

    logic [FIFO_WIDTH-1:0] mem_q [D];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q,  count_d;
    logic                  full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]) &&
                   (wr_ptr_q[PW-1]   != rd_ptr_q[PW-1]);

    // s_ready is a pure function of state so m_ready never reaches it.
    assign s_ready     = ~full;
    assign m_valid     = ~empty;
    assign m_data      = mem_q[rd_ptr_q[PW-2:0]];
    assign count       = count_q;
    assign almost_full = (count_q >= AFULL);

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; a flushed push is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[PW-2:0]] <= s_data;
    end

endmodule

// File: tb/tb_std_fifo_sync_vr.sv
// Directed bench for std_fifo_sync_vr (D=4, WIDTH=8, AFULL=3).
// Inputs change just after negedge; outputs are sampled at negedge.
module tb_std_fifo_sync_vr;

    logic       clk = 1'b0;
    logic       resetn, flush, s_valid, s_ready, m_valid, m_ready, almost_full;
    logic [7:0] s_data, m_data;
    logic [2:0] count;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    std_fifo_sync_vr #(
        .FIFO_WIDTH(8), .FIFO_DEPTH_LOG2(2), .FIFO_AFULL_LEVEL(3)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .almost_full(almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push1(input logic [7:0] d);
        s_valid = 1'b1; s_data = d;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        #12;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_count",   count,   0);
        chk("rst_afull",   almost_full, 0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // 1: fill to full with no pops
        for (int i = 0; i < 4; i++) begin
            push1(8'((i + 1) * 8'h11));
            chk("fill_count", count, i + 1);
            chk("fill_afull", almost_full, (i >= 2) ? 1 : 0);
            chk("fill_head",  m_data, 8'h11);
            chk("fill_s_ready", s_ready, (i == 3) ? 0 : 1);
        end

        // 2: push attempt while full plus a pop: only the pop happens
        s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b1;
        step();
        s_valid = 1'b0; m_ready = 1'b0;
        chk("full_pop_count", count, 3);
        chk("full_pop_s_ready", s_ready, 1);
        chk("full_pop_head", m_data, 8'h22);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_data", m_data, 8'((i + 2) * 8'h11));
            step();
        end
        m_ready = 1'b0;
        chk("drain_m_valid", m_valid, 0);
        chk("drain_count", count, 0);

        // 3: streaming at count=2, 12 entries in total, pointers wrap 3 times
        push1(8'h01);
        push1(8'h02);
        for (int k = 3; k <= 12; k++) begin
            chk("stream_count", count, 2);
            chk("stream_data", m_data, 8'(k - 2));
            s_valid = 1'b1; s_data = 8'(k); m_ready = 1'b1;
            step();
        end
        s_valid = 1'b0;
        for (int k = 11; k <= 12; k++) begin
            chk("stream_tail", m_data, 8'(k));
            step();
        end
        m_ready = 1'b0;
        chk("stream_empty", m_valid, 0);
        chk("stream_count0", count, 0);

        // 4: fall-through latency from empty
        chk("lat_pre_valid", m_valid, 0);
        push1(8'hA5);
        chk("lat_post_valid", m_valid, 1);
        chk("lat_post_data", m_data, 8'hA5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("lat_pop_valid", m_valid, 0);
        chk("lat_pop_count", count, 0);

        // 5: flush beats a simultaneous push and pop
        push1(8'h61); push1(8'h62); push1(8'h63);
        chk("pre_flush_count", count, 3);
        flush = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
        chk("flush_cycle_valid", m_valid, 1);
        step();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_m_valid", m_valid, 0);
        chk("flush_s_ready", s_ready, 1);
        push1(8'h88);
        chk("post_flush_head", m_data, 8'h88);
        chk("post_flush_count", count, 1);

        // 6: asynchronous reset between edges
        push1(8'h89);
        chk("pre_rst_count", count, 2);
        #2 resetn = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_s_ready", s_ready, 1);
        #1 resetn = 1'b1;
        @(negedge clk);
        push1(8'h3C);
        chk("post_rst_valid", m_valid, 1);
        chk("post_rst_head", m_data, 8'h3C);
        chk("post_rst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
